// File: rtl/sr_trace_pkg.sv
// sr_trace_pkg: shared types and constants for the sr_cpu commit-trace transmitter.
// Optional drop marker is enabled by defining SR_TRACE_DROPMARK_EN.
package sr_trace_pkg;

    localparam int unsigned ENTRY_W      = 102;
    localparam int unsigned REC_LEN_NOWD = 9;
    localparam int unsigned REC_LEN_WD   = 13;

    // Header byte layout: {1'b1, we, 1'b0, rd}
    localparam int unsigned HDR_FLAG_BIT = 7;
    localparam int unsigned HDR_WE_BIT   = 6;
    localparam int unsigned HDR_ZERO_BIT = 5;
    localparam int unsigned HDR_RD_LSB   = 0;

    // Drop marker lead byte; bit7=0 keeps it distinct from a header
    localparam logic [7:0] MARK_BYTE = 8'h7F;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StPc,
        StInstr,
        StWd,
        StMark
    } tx_state_e;

    // Packed MSB-first so the flat vector is {we, rd, wd, instr, pc}
    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] instr;
        logic [31:0] pc;
    } trace_entry_t;

    function automatic logic [7:0] hdr_byte(input logic we, input logic [4:0] rd);
        logic [7:0] h;
        h = 8'h00;
        h[HDR_FLAG_BIT]    = 1'b1;
        h[HDR_WE_BIT]      = we;
        h[HDR_ZERO_BIT]    = 1'b0;
        h[HDR_RD_LSB +: 5] = rd;
        return h;
    endfunction

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        unique case (idx)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            2'd3: b = w[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sr_trace_fifo.sv
// sr_trace_fifo: generic synchronous FIFO with full/empty flags.
// Pushes while full and pops while empty are ignored.
module sr_trace_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Storage array; no reset needed, contents are qualified by count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sr_trace_tx.sv
// sr_trace_tx: commit-trace transmitter. Queues one record per committed instruction and
// serializes it LSB-first as bytes on a valid/ready stream.
// Define SR_TRACE_DROPMARK_EN to emit a {0x7F, dropCnt} marker ahead of the record popped
// after commits were dropped.
module sr_trace_tx
    import sr_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trEn,
    input  logic        commitValid,
    input  logic [31:0] commitPc,
    input  logic [31:0] commitInstr,
    input  logic        commitWe,
    input  logic [4:0]  commitRd,
    input  logic [31:0] commitWd,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    trace_entry_t commit_entry;
    trace_entry_t head;
    trace_entry_t sr;
    tx_state_e    state;
    logic [1:0]   idx;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         drop;
    logic         pop;
    logic         beat;
    logic         rec_done;
    logic         can_start;

    assign commit_entry = {commitWe, commitRd, commitWd, commitInstr, commitPc};
    assign push         = commitValid & trEn & ~fifo_full;
    assign drop         = commitValid & trEn & fifo_full;
    assign beat         = txValid & txReady;
    assign rec_done     = beat && (idx == 2'd3) &&
                          (((state == StInstr) && !sr.we) || (state == StWd));

`ifdef SR_TRACE_DROPMARK_EN
    logic [7:0] drop_cnt;
    logic       mark_done;
    logic       start_mark;

    assign mark_done  = beat && (state == StMark) && (idx == 2'd1);
    assign can_start  = (state == StIdle) || rec_done || mark_done;
    // After the marker completes the held record goes out even if a new drop just landed
    assign start_mark = can_start && !fifo_empty && (drop_cnt != 8'd0) && !mark_done;
    assign pop        = can_start && !fifo_empty && !start_mark;

    // Saturating drop counter; a drop coinciding with the marker's last beat survives as 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (mark_done) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign can_start = (state == StIdle) || rec_done;
    assign pop       = can_start && !fifo_empty;
`endif

    assign busy = !fifo_empty || (state != StIdle);

    sr_trace_fifo #(
        .DATA_W(ENTRY_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(commit_entry),
        .pop  (pop),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Sticky loss flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Serializer FSM; txData/txValid are registered and only change on a beat or a pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            idx     <= 2'd0;
            sr      <= '0;
            txData  <= 8'h00;
            txValid <= 1'b0;
        end else if (pop) begin
            sr      <= head;
            state   <= StHdr;
            idx     <= 2'd0;
            txData  <= hdr_byte(head.we, head.rd);
            txValid <= 1'b1;
`ifdef SR_TRACE_DROPMARK_EN
        end else if (start_mark) begin
            state   <= StMark;
            idx     <= 2'd0;
            txData  <= MARK_BYTE;
            txValid <= 1'b1;
`endif
        end else if (can_start) begin
            state   <= StIdle;
            idx     <= 2'd0;
            txValid <= 1'b0;
        end else if (beat) begin
            unique case (state)
                StHdr: begin
                    state  <= StPc;
                    idx    <= 2'd0;
                    txData <= word_byte(sr.pc, 2'd0);
                end
                StPc: begin
                    if (idx == 2'd3) begin
                        state  <= StInstr;
                        idx    <= 2'd0;
                        txData <= word_byte(sr.instr, 2'd0);
                    end else begin
                        idx    <= idx + 2'd1;
                        txData <= word_byte(sr.pc, idx + 2'd1);
                    end
                end
                StInstr: begin
                    // idx==3 with we=0 ends the record via can_start
                    if (idx == 2'd3) begin
                        state  <= StWd;
                        idx    <= 2'd0;
                        txData <= word_byte(sr.wd, 2'd0);
                    end else begin
                        idx    <= idx + 2'd1;
                        txData <= word_byte(sr.instr, idx + 2'd1);
                    end
                end
                StWd: begin
                    idx    <= idx + 2'd1;
                    txData <= word_byte(sr.wd, idx + 2'd1);
                end
`ifdef SR_TRACE_DROPMARK_EN
                StMark: begin
                    idx    <= 2'd1;
                    txData <= drop_cnt;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_trace_tx.sv
// tb_sr_trace_tx: directed and randomized bench for sr_trace_tx against a byte-queue model.
// Honours SR_TRACE_DROPMARK_EN when compiled with the same define as the design.
module tb_sr_trace_tx;
    import sr_trace_pkg::*;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] wd;
    } rec_t;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trEn = 1'b0;
    logic        commitValid = 1'b0;
    logic [31:0] commitPc = '0;
    logic [31:0] commitInstr = '0;
    logic        commitWe = 1'b0;
    logic [4:0]  commitRd = '0;
    logic [31:0] commitWd = '0;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady = 1'b0;
    logic        overflow;
    logic        busy;

    always #5 clk = ~clk;

    sr_trace_tx #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .trEn       (trEn),
        .commitValid(commitValid),
        .commitPc   (commitPc),
        .commitInstr(commitInstr),
        .commitWe   (commitWe),
        .commitRd   (commitRd),
        .commitWd   (commitWd),
        .txData     (txData),
        .txValid    (txValid),
        .txReady    (txReady),
        .overflow   (overflow),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queued records, bytes still owed for the record in flight
    rec_t       m_q[$];
    logic [7:0] m_bytes[$];
    logic       m_ovf = 1'b0;
    int         m_drops = 0;
    int         m_stage = 0;  // 0 record, 1 marker lead byte, 2 marker count byte
    logic [7:0] got[$];

    logic [7:0] exp_a[13] = '{8'hC1, 8'h10, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                              8'h05, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp_b[9]  = '{8'h9D, 8'h14, 8'h00, 8'h00, 8'h00, 8'hE3, 8'h0E, 8'h00, 8'hFE};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                                input logic we, input logic [4:0] rd, input logic [31:0] wd);
        rec_t r;
        r.pc = pc; r.instr = instr; r.we = we; r.rd = rd; r.wd = wd;
        return r;
    endfunction

    function automatic rec_t rnd_rec();
        return mk($urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom);
    endfunction

    function automatic bq_t fmt(input rec_t r);
        bq_t b;
        b.push_back({1'b1, r.we, 1'b0, r.rd});
        for (int i = 0; i < 4; i++) b.push_back(r.pc[8*i +: 8]);
        for (int i = 0; i < 4; i++) b.push_back(r.instr[8*i +: 8]);
        if (r.we) for (int i = 0; i < 4; i++) b.push_back(r.wd[8*i +: 8]);
        return b;
    endfunction

    // One clock edge of the reference, using the inputs presented before the edge
    function automatic void model_edge(input bit v, input bit en, input bit ready,
                                       input rec_t r);
        bit full;
        bit drop_now;
        bit start;
        bit mark_end;
        full     = (m_q.size() == DEPTH);
        drop_now = v && en && full;
        start    = (m_bytes.size() == 0);
        mark_end = 1'b0;
        if (m_bytes.size() != 0 && ready) begin
            void'(m_bytes.pop_front());
            if (m_stage == 1) begin
                m_bytes.push_back(8'(m_drops));
                m_stage = 2;
            end else if (m_bytes.size() == 0) begin
                start = 1'b1;
                if (m_stage == 2) begin
                    mark_end = 1'b1;
                    m_stage  = 0;
                end
            end
        end
        if (start && m_q.size() != 0) begin
`ifdef SR_TRACE_DROPMARK_EN
            if (m_drops != 0 && !mark_end) begin
                m_bytes.push_back(MARK_BYTE);
                m_stage = 1;
            end else begin
                m_bytes = fmt(m_q.pop_front());
            end
`else
            m_bytes = fmt(m_q.pop_front());
`endif
        end
        if (mark_end) m_drops = drop_now ? 1 : 0;
        else if (drop_now && m_drops < 255) m_drops++;
        if (drop_now) m_ovf = 1'b1;
        if (v && en && !full) m_q.push_back(r);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ":txValid"}, 32'(txValid), 32'(m_bytes.size() != 0));
        if (m_bytes.size() != 0) chk({tag, ":txData"}, 32'(txData), 32'(m_bytes[0]));
        chk({tag, ":busy"}, 32'(busy), 32'(m_bytes.size() != 0 || m_q.size() != 0));
        chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // Present inputs for one cycle, advance the model at the edge, check at the falling edge
    task automatic cycle(input string tag, input bit v, input bit en, input bit ready,
                         input rec_t r);
        commitValid = v; trEn = en; txReady = ready;
        commitPc = r.pc; commitInstr = r.instr; commitWe = r.we; commitRd = r.rd;
        commitWd = r.wd;
        if (txValid && txReady) got.push_back(txData);
        @(posedge clk);
        model_edge(v, en, ready, r);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n, input bit ready);
        for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b1, ready, rnd_rec());
    endtask

    // Raise rst away from any clock edge so its effect is seen asynchronously
    task automatic do_reset(input string tag);
        rst = 1'b1;
        #2;
        chk({tag, ":rst_txValid"}, 32'(txValid), 32'd0);
        chk({tag, ":rst_txData"}, 32'(txData), 32'd0);
        chk({tag, ":rst_busy"}, 32'(busy), 32'd0);
        chk({tag, ":rst_overflow"}, 32'(overflow), 32'd0);
        m_q.delete(); m_bytes.delete(); m_ovf = 1'b0; m_drops = 0; m_stage = 0;
        commitValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_len;
        @(negedge clk);
        do_reset("init");

        // Single commit with register write
        got.delete();
        cycle("a_commit", 1'b1, 1'b1, 1'b1, mk(32'h10, 32'h00500093, 1'b1, 5'd1, 32'd5));
        idle("a_drain", 16, 1'b1);
        chk("a_len", 32'(got.size()), 32'(REC_LEN_WD));
        for (int i = 0; i < 13; i++) chk($sformatf("a_byte%0d", i), 32'(got[i]), 32'(exp_a[i]));

        // Commit without register write; header still carries rd
        got.delete();
        cycle("b_commit", 1'b1, 1'b1, 1'b1, mk(32'h14, 32'hFE000EE3, 1'b0, 5'd29, 32'h0));
        idle("b_drain", 12, 1'b1);
        chk("b_len", 32'(got.size()), 32'(REC_LEN_NOWD));
        for (int i = 0; i < 9; i++) chk($sformatf("b_byte%0d", i), 32'(got[i]), 32'(exp_b[i]));

        // Back-to-back commits with txReady toggling every cycle
        for (int i = 0; i < 40; i++)
            cycle("c_toggle", i < 6, 1'b1, 1'(i % 2), rnd_rec());
        idle("c_drain", 80, 1'b1);

        // Fully random traffic
        for (int i = 0; i < 400; i++)
            cycle("r_rand", 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                  1'($urandom_range(0, 1)), rnd_rec());
        idle("r_drain", 80, 1'b1);

        // Overflow: stalled consumer, six commits. The first record is already popped into
        // the serializer, so the FIFO takes four more and the sixth commit is dropped.
        do_reset("d");
        got.delete();
        for (int i = 0; i < 6; i++)
            cycle("d_fill", 1'b1, 1'b1, 1'b0, mk(32'(i), 32'h13, 1'b1, 5'(i), 32'(i)));
        idle("d_hold", 4, 1'b0);
        chk("d_overflow", 32'(overflow), 32'd1);
        idle("d_release", 90, 1'b1);
        exp_len = 5 * REC_LEN_WD;
`ifdef SR_TRACE_DROPMARK_EN
        exp_len += 2;
`endif
        chk("d_len", 32'(got.size()), 32'(exp_len));
        chk("d_overflow_sticky", 32'(overflow), 32'd1);

        // trEn low ignores commits; dropping it mid-record lets the record finish
        do_reset("e");
        for (int i = 0; i < 3; i++) cycle("e_off", 1'b1, 1'b0, 1'b1, rnd_rec());
        chk("e_no_valid", 32'(txValid), 32'd0);
        cycle("e_on", 1'b1, 1'b1, 1'b1, rnd_rec());
        for (int i = 0; i < 6; i++) cycle("e_mid", 1'b1, 1'b0, 1'b1, rnd_rec());
        idle("e_drain", 12, 1'b1);

        // Reset in the middle of the pc bytes, then a fresh record
        cycle("f_commit", 1'b1, 1'b1, 1'b1, mk(32'h1234, 32'h5678, 1'b1, 5'd3, 32'h9));
        idle("f_run", 3, 1'b1);
        chk("f_inflight", 32'(txValid), 32'd1);
        do_reset("f");
        got.delete();
        cycle("f_fresh", 1'b1, 1'b1, 1'b1, mk(32'h20, 32'h0, 1'b0, 5'd7, 32'h0));
        idle("f_drain", 12, 1'b1);
        chk("f_header", 32'(got[0]), 32'h87);
        chk("f_len", 32'(got.size()), 32'(REC_LEN_NOWD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
